smd_multipad_encoder: RTL and testbench
=======================================

// Module: smd_multipad_encoder
// PURPOSE
//  Next-generation Genesis/Mega Drive pad encoder: NUM_PORTS independent ports.
//  Each port answers its console SELECT (pin 7) with 3- or 6-button protocol data.
//  Synchronous design: SELECT is synchronised, edges are counted per frame, and the
//  edge count resets on an idle timeout. Sits between button debouncers and DB9 pads.
// PARAMETERS
//  NUM_PORTS       2      number of independent pad ports (1..4)
//  TIMEOUT_CYCLES  15000  clk cycles without a SELECT edge before frame reset (1.5ms @10MHz)
//  FILTER_CYCLES   4      SELECT stability window, used only with SMD_GLITCH_FILTER_EN
// PORTS
//  clk      in   1            system clock
//  rst_n    in   1            asynchronous active-low reset
//  sel      in   NUM_PORTS    console SELECT per port, asynchronous to clk
//  six_en   in   NUM_PORTS    1 = 6-button protocol, 0 = 3-button only (quasi-static)
//  btn      in   12*NUM_PORTS active-low buttons; port i = btn[12*i +: 12]
//                             = {md,z,y,x,st,c,b,a,rg,lf,dw,up}
//  pad      out  6*NUM_PORTS  DB9 data; port i = pad[6*i +: 6], bit5..0 = pins 1,2,3,4,6,9
// BEHAVIOUR
//  Reset: pad = all 1s, sync flops = 1, n = 0, timeout counter = TIMEOUT_CYCLES.
//  Per port, fully independent, identical logic:
//  - sel passes a 2-flop synchroniser -> s; edge = s != s_prev (registered).
//  - n (3 bits) = falling edges of s since frame start; increments on each falling
//    edge, saturates at 5 (no wrap). Rising edges do not change n.
//  - Timeout counter reloads to TIMEOUT_CYCLES on any edge, else decrements;
//    on reaching 0: n <= 0, counter reloads.
//  - Edge and timeout expiry in the same cycle: frame restarts, then the edge is
//    applied (falling -> n = 1, rising -> n = 0); counter reloads.
//  - btn sampled into a register every cycle; table uses the registered copy.
//  Output table (registered, uses updated n and s; n_eff = six_en ? n : min(n,1)):
//    s=1, n_eff!=3  : {up,dw,lf,rg,b,c}
//    s=1, n_eff==3  : {z,y,x,md,1,1}
//    s=0, n_eff<=2  : {up,dw,0,0,a,st}
//    s=0, n_eff==3  : {0,0,0,0,a,st}    (6-button ID)
//    s=0, n_eff==4  : {1,1,1,1,a,st}
//    s=0, n_eff==5  : {up,dw,0,0,a,st}
//  Latency: sel pin change -> pad update in 3 clk (2 sync + 1 output reg).
//  Button change -> pad update in 2 clk.
//  six_en change mid-frame takes effect on the next output register update.
//  Async reset mid-frame: immediate return to reset values; next edge starts n=1.
// CONFIGURATION
//  SMD_GLITCH_FILTER_EN defined: synchronised s must hold a new level for
//    FILTER_CYCLES consecutive clk before it is accepted as an edge; shorter pulses
//    are ignored (no n change, no counter reload). Latency = 3 + FILTER_CYCLES clk.
//  Not defined: every synchronised transition is an edge; FILTER_CYCLES unused.
// TESTING
//  1. Reset, sel=1 held, btn all 1 except up=0 -> pad[5:0]=6'b011111 from 2 clk on.
//  2. six_en=1, four SELECT pulses (low 2us, high 2us), a=0,x=0 -> lows read
//     {up,dw,0,0,a,st},{same},{0,0,0,0,0,1},{1,1,1,1,0,1}; 3rd high = 6'b110111.
//  3. six_en=0, same stimulus -> 3rd low = {1,1,0,0,0,1}, 3rd high = {1,1,1,1,1,1}.
//  4. Two pulses, idle TIMEOUT_CYCLES+1 clk, two more pulses -> 2nd low of new frame
//     is normal (n=2), not ID; idle TIMEOUT_CYCLES-2 instead -> ID pattern seen.
//  5. Falling edge landing on timeout-expiry cycle -> n=1 afterwards, counter reloaded.
//  6. Port 0 pulsed 3 times, port 1 idle -> pad[11:6] stays normal-high, unaffected;
//     with SMD_GLITCH_FILTER_EN, a 2-clk SELECT glitch -> no n change, pad unchanged.

Source files
------------

// File: rtl/smd_multipad_encoder.sv
// Genesis/Mega Drive multi-port pad encoder: answers each console SELECT with 3/6-button data.
// Optional macro SMD_GLITCH_FILTER_EN adds a SELECT stability filter of FILTER_CYCLES clk.
module smd_multipad_encoder #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 15000,
    parameter int unsigned FILTER_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    sel,
    input  logic [NUM_PORTS-1:0]    six_en,
    input  logic [12*NUM_PORTS-1:0] btn,
    output logic [6*NUM_PORTS-1:0]  pad
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned N_W   = 3;
    localparam logic [N_W-1:0] N_MAX = N_W'(5);

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic             s_meta;
        logic             s_sync;
        logic             s_cur;
        logic             s_new_c;
        logic             sel_edge_c;
        logic             fall_c;
        logic             expire_c;
        logic [N_W-1:0]   n_q;
        logic [N_W-1:0]   n_base_c;
        logic [N_W-1:0]   n_next_c;
        logic [N_W-1:0]   n_eff_c;
        logic [CNT_W-1:0] cnt_q;
        logic [11:0]      btn_q;
        logic [5:0]       pad_q;
        logic [5:0]       pad_next_c;

        // Two-flop synchroniser for the asynchronous console SELECT
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_meta <= 1'b1;
                s_sync <= 1'b1;
            end else begin
                s_meta <= sel[gi];
                s_sync <= s_meta;
            end
        end

`ifdef SMD_GLITCH_FILTER_EN
        localparam int unsigned FLT_W = $clog2(FILTER_CYCLES + 1);
        logic [FLT_W-1:0] flt_q;
        logic             accept_c;

        // A new level is accepted only once it has outlasted the stability window
        assign accept_c = (s_sync != s_cur) && (flt_q == FLT_W'(FILTER_CYCLES));
        assign s_new_c  = accept_c ? s_sync : s_cur;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flt_q <= '0;
            end else if ((s_sync == s_cur) || accept_c) begin
                flt_q <= '0;
            end else begin
                flt_q <= flt_q + FLT_W'(1);
            end
        end
`else
        assign s_new_c = s_sync;
`endif

        assign sel_edge_c = (s_new_c != s_cur);
        assign fall_c     = sel_edge_c & ~s_new_c;
        assign expire_c   = (cnt_q == '0);

        // Frame restart happens before the coincident edge is counted
        always_comb begin
            n_base_c = expire_c ? '0 : n_q;
            n_next_c = n_base_c;
            if (fall_c && (n_base_c != N_MAX)) begin
                n_next_c = n_base_c + N_W'(1);
            end
            n_eff_c = n_next_c;
            if (!six_en[gi] && (n_next_c > N_W'(1))) begin
                n_eff_c = N_W'(1);
            end

            pad_next_c = {btn_q[0], btn_q[1], btn_q[2], btn_q[3], btn_q[5], btn_q[6]};
            if (s_new_c) begin
                if (n_eff_c == N_W'(3)) begin
                    pad_next_c = {btn_q[10], btn_q[9], btn_q[8], btn_q[11], 2'b11};
                end
            end else begin
                case (n_eff_c)
                    N_W'(3): pad_next_c = {4'b0000, btn_q[4], btn_q[7]};
                    N_W'(4): pad_next_c = {4'b1111, btn_q[4], btn_q[7]};
                    default: pad_next_c = {btn_q[0], btn_q[1], 2'b00, btn_q[4], btn_q[7]};
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_cur <= 1'b1;
                n_q   <= '0;
                cnt_q <= CNT_W'(TIMEOUT_CYCLES);
                btn_q <= '1;
                pad_q <= '1;
            end else begin
                s_cur <= s_new_c;
                n_q   <= n_next_c;
                cnt_q <= (sel_edge_c || expire_c) ? CNT_W'(TIMEOUT_CYCLES) : cnt_q - CNT_W'(1);
                btn_q <= btn[12*gi +: 12];
                pad_q <= pad_next_c;
            end
        end

        assign pad[6*gi +: 6] = pad_q;
    end

endmodule

// File: tb/tb_smd_multipad_encoder.sv
// Bench for smd_multipad_encoder: directed vector table, hand sequences and a randomized
// run against a frame-level reference model.
module tb_smd_multipad_encoder;

    localparam int NP = 2;
    localparam int T  = 60;
    localparam int F  = 4;
`ifdef SMD_GLITCH_FILTER_EN
    localparam int EXTRA = F;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT    = 2 + EXTRA;
    localparam int PW     = 10;
    localparam int MINRUN = (EXTRA > 0) ? F + 1 : 1;

    localparam logic [11:0] BTN_AX = 12'hEEF;
    localparam logic [11:0] BTN_B2 = 12'h33A;
    localparam logic [11:0] BTN_P1 = 12'hFF6;
    localparam logic [5:0]  P1_HI  = 6'b011011;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NP-1:0]   sel;
    logic [NP-1:0]   six_en;
    logic [12*NP-1:0] btn;
    logic [6*NP-1:0] pad;

    smd_multipad_encoder #(
        .NUM_PORTS(NP),
        .TIMEOUT_CYCLES(T),
        .FILTER_CYCLES(F)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .six_en(six_en),
        .btn(btn),
        .pad(pad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: pin history delayed by the sync path, falls counted per frame
    bit          sel_hist [NP][$];
    logic [11:0] btn_d    [NP];
    bit          s_prev   [NP];
    int          falls    [NP];
    int          ref_cyc  [NP];
    logic [5:0]  exp_pad  [NP];
    int          cyc;

    function automatic logic [5:0] pad_of(input bit s, input int neff, input logic [11:0] b);
        logic up = b[0], dw = b[1], lf = b[2], rg = b[3];
        logic a = b[4], bb = b[5], c = b[6], st = b[7];
        logic x = b[8], y = b[9], z = b[10], md = b[11];
        if (s) return (neff == 3) ? {z, y, x, md, 2'b11} : {up, dw, lf, rg, bb, c};
        if (neff == 3) return {4'b0000, a, st};
        if (neff == 4) return {4'b1111, a, st};
        return {up, dw, 2'b00, a, st};
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int p = 0; p < NP; p++) begin
            sel_hist[p].delete();
            repeat (LAT) sel_hist[p].push_back(1'b1);
            btn_d[p]   = '1;
            s_prev[p]  = 1'b1;
            falls[p]   = 0;
            ref_cyc[p] = 0;
            exp_pad[p] = '1;
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int p = 0; p < NP; p++) begin
            bit s;
            int n;
            int neff;
            s = sel_hist[p].pop_front();
            sel_hist[p].push_back(sel[p]);
            if (cyc - ref_cyc[p] == T + 1) begin
                falls[p]   = 0;
                ref_cyc[p] = cyc;
            end
            if (s != s_prev[p]) begin
                ref_cyc[p] = cyc;
                if (!s) falls[p]++;
            end
            s_prev[p]  = s;
            n          = (falls[p] > 5) ? 5 : falls[p];
            neff       = six_en[p] ? n : ((n > 0) ? 1 : 0);
            exp_pad[p] = pad_of(s, neff, btn_d[p]);
            btn_d[p]   = btn[12*p +: 12];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_pad0", pad[5:0], 6'h3F);
        check("reset_pad1", pad[11:6], 6'h3F);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int lo_len, input int hi_len);
        sel[0] = 1'b0;
        repeat (lo_len) tick();
        sel[0] = 1'b1;
        repeat (hi_len) tick();
    endtask

    typedef struct {
        bit          six;
        logic [11:0] b;
        int          k;
        logic [5:0]  lo;
        logic [5:0]  hi;
    } vec_t;

    vec_t vecs[$];

    task automatic run_idle(input int h, input logic [5:0] exp1, input logic [5:0] exp3,
                            input string tag);
        six_en = '1;
        btn    = {BTN_P1, BTN_AX};
        sel    = '1;
        apply_reset();
        repeat (4) tick();
        pulse(PW, PW);
        pulse(PW, h);
        for (int j = 1; j <= 3; j++) begin
            sel[0] = 1'b0;
            repeat (PW) tick();
            if (j == 1) check({tag, "_low1"}, pad[5:0], exp1);
            if (j == 3) check({tag, "_low3"}, pad[5:0], exp3);
            sel[0] = 1'b1;
            repeat (PW) tick();
        end
    endtask

    initial begin
        int run [NP];

        sel    = '1;
        six_en = '1;
        btn    = {BTN_P1, 12'hFFE};
        #1;

        // Reset values, button latency and SELECT latency
        apply_reset();
        tick();
        check("btn_lat1", pad[5:0], 6'b111111);
        tick();
        check("btn_lat2", pad[5:0], 6'b011111);
        sel[0] = 1'b0;
        repeat (LAT) tick();
        check("sel_lat_before", pad[5:0], 6'b011111);
        tick();
        check("sel_lat_after", pad[5:0], 6'b010011);
        check("port1_idle", pad[11:6], P1_HI);

        // Pulse-count table
        vecs.push_back('{1'b1, BTN_AX, 1, 6'b110001, 6'b111111});
        vecs.push_back('{1'b1, BTN_AX, 3, 6'b000001, 6'b110111});
        vecs.push_back('{1'b1, BTN_AX, 4, 6'b111101, 6'b111111});
        vecs.push_back('{1'b0, BTN_AX, 3, 6'b110001, 6'b111111});
        vecs.push_back('{1'b0, BTN_AX, 4, 6'b110001, 6'b111111});
        vecs.push_back('{1'b1, BTN_B2, 1, 6'b010010, 6'b010110});
        vecs.push_back('{1'b1, BTN_B2, 3, 6'b000010, 6'b011011});
        vecs.push_back('{1'b1, BTN_B2, 4, 6'b111110, 6'b010110});
        vecs.push_back('{1'b1, BTN_B2, 6, 6'b010010, 6'b010110});
        vecs.push_back('{1'b0, BTN_B2, 3, 6'b010010, 6'b010110});
        foreach (vecs[i]) begin
            six_en = {1'b1, vecs[i].six};
            btn    = {BTN_P1, vecs[i].b};
            sel    = '1;
            apply_reset();
            repeat (4) tick();
            for (int j = 1; j <= vecs[i].k; j++) begin
                sel[0] = 1'b0;
                repeat (PW) tick();
                if (j == vecs[i].k) check($sformatf("vec%0d_low", i), pad[5:0], vecs[i].lo);
                sel[0] = 1'b1;
                repeat (PW) tick();
                if (j == vecs[i].k) begin
                    check($sformatf("vec%0d_high", i), pad[5:0], vecs[i].hi);
                    check($sformatf("vec%0d_port1", i), pad[11:6], P1_HI);
                end
            end
        end

        // Idle timeout around the threshold, including edge on the expiry cycle
        run_idle(T - 2, 6'b000001, 6'b110001, "idle_short");
        run_idle(T + 1, 6'b110001, 6'b000001, "idle_coincide");
        run_idle(T + 6, 6'b110001, 6'b000001, "idle_long");

        // Asynchronous reset in the middle of a frame
        six_en = '1;
        btn    = {BTN_P1, BTN_AX};
        sel    = '1;
        apply_reset();
        repeat (4) tick();
        pulse(PW, PW);
        pulse(PW, PW);
        sel[0] = 1'b0;
        repeat (3) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_pad0", pad[5:0], 6'h3F);
        check("midreset_pad1", pad[11:6], 6'h3F);
        @(negedge clk);
        model_reset();
        sel = '1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        pulse(PW, PW);
        pulse(PW, PW);
        sel[0] = 1'b0;
        repeat (PW) tick();
        check("midreset_restart", pad[5:0], 6'b000001);
        sel[0] = 1'b1;
        repeat (PW) tick();

`ifdef SMD_GLITCH_FILTER_EN
        // Short SELECT glitch must be ignored
        apply_reset();
        repeat (4) tick();
        pulse(PW, PW);
        pulse(PW, PW);
        sel[0] = 1'b0;
        repeat (2) tick();
        sel[0] = 1'b1;
        repeat (PW) tick();
        check("glitch_hold", pad[5:0], 6'b111111);
        sel[0] = 1'b0;
        repeat (PW) tick();
        check("glitch_n", pad[5:0], 6'b000001);
        sel[0] = 1'b1;
        repeat (PW) tick();
`endif

        // Randomized run against the reference model
        six_en = NP'($urandom);
        btn    = (12*NP)'({$urandom, $urandom});
        sel    = '1;
        apply_reset();
        for (int p = 0; p < NP; p++) run[p] = $urandom_range(MINRUN, 12);
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("rand_p%0d_c%0d", p, c), pad[6*p +: 6], exp_pad[p]);
                if (run[p] == 0) begin
                    sel[p] = ~sel[p];
                    run[p] = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 4, T + 4)
                                                        : $urandom_range(MINRUN, 12);
                end
                run[p]--;
                if ($urandom_range(0, 7) == 0) btn[12*p +: 12] = 12'($urandom);
                if ($urandom_range(0, 63) == 0) six_en[p] = ~six_en[p];
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
